// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter that shares the register file write port among NUM_REQ writeback sources,
// plus a pending-write scoreboard that stalls the issue stage on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REQ   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [5*NUM_REQ-1:0]         req_rd,
    input  logic [WORD_SIZE*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         issue_valid,
    input  logic [4:0]                   issue_rd,
    input  logic [4:0]                   issue_rs1,
    input  logic [4:0]                   issue_rs2,
    output logic                         issue_stall,
    output logic                         rf_en,
    output logic [4:0]                   rf_rd,
    output logic [WORD_SIZE-1:0]         rf_data,
    output logic [31:0]                  pending
);

    localparam int IDXW = $clog2(NUM_REQ);

    logic [IDXW-1:0]      lastGrant_q;
    logic                 rfEn_q;
    logic [4:0]           rfRd_q;
    logic [WORD_SIZE-1:0] rfData_q;
    logic [31:0]          pending_q;
    logic [31:0]          pending_d;

    logic [IDXW-1:0]      cand;
    logic [IDXW-1:0]      grantIdx;
    logic                 grantFound;
    logic [4:0]           selRd;
    logic [WORD_SIZE-1:0] selData;

    // Search starts just after the last winner so every source gets a turn.
    always_comb begin
        cand       = '0;
        grantIdx   = '0;
        grantFound = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDXW'((int'(lastGrant_q) + off) % NUM_REQ);
            if (!grantFound && req_valid[cand]) begin
                grantFound = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grantFound) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    assign selRd   = req_rd[grantIdx*5 +: 5];
    assign selData = req_data[grantIdx*WORD_SIZE +: WORD_SIZE];

    // Register 0 is never pending, so source or destination 0 cannot stall.
    assign issue_stall = issue_valid &
                         (pending_q[issue_rs1] | pending_q[issue_rs2] | pending_q[issue_rd]);

    always_comb begin
        pending_d = pending_q;
        if (rfEn_q) begin
            pending_d[rfRd_q] = 1'b0;
        end
        if (issue_valid && !issue_stall && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant_q <= IDXW'(NUM_REQ - 1);
            rfEn_q      <= 1'b0;
            rfRd_q      <= '0;
            rfData_q    <= '0;
            pending_q   <= '0;
        end else begin
            rfEn_q    <= grantFound && (selRd != 5'd0);
            pending_q <= pending_d;
            if (grantFound) begin
                lastGrant_q <= grantIdx;
                rfRd_q      <= selRd;
                rfData_q    <= selData;
            end
        end
    end

    assign rf_en   = rfEn_q;
    assign rf_rd   = rfRd_q;
    assign rf_data = rfData_q;
    assign pending = pending_q;

endmodule
